pe_array_os: RTL and testbench
==============================

// Module: pe_array_os
// PURPOSE
//  Output-stationary systolic matrix-multiply array of ROW_len x COL_len signed MAC PEs.
//  A-operands enter per row from the left and B-operands per column from the top, externally skewed.
//  Each PE(i,j) accumulates C[i][j] in place; results drain one row per cycle through the bottom edge.
//  Sits between the operand skew/feed logic and the result collector of the accelerator datapath.
// PARAMETERS
//  ROW_len  4   number of PE rows (rows of A / C)
//  COL_len  5   number of PE columns (columns of B / C)
//  DW       8   signed operand width
//  ACCW     16  signed accumulator / result width
// PORTS
//  clk         in   1             single clock, all state updates on rising edge
//  rst_n       in   1             reset, synchronous, active-low
//  compute_en  in   1             advance operand pipelines and enable MAC
//  read_en_in  in   1             drain results: shift accumulator rows toward bottom edge
//  a_bus       in   ROW_len*DW    row i operand at bits [(i+1)*DW-1 -: DW], signed
//  b_bus       in   COL_len*DW    column j operand at bits [(j+1)*DW-1 -: DW], signed
//  c_bus       out  COL_len*ACCW  bottom-row results, column j at bits [(j+1)*ACCW-1 -: ACCW]
// BEHAVIOUR
//  - State: a_reg[i][j], b_reg[i][j] (DW), acc[i][j] (ACCW), all PEs.
//  - Reset (rst_n=0 at posedge): all a_reg/b_reg/acc cleared to 0; c_bus therefore 0. Overrides all.
//  - Operand flow, when compute_en=1 (independent of read_en_in):
//      a_reg[i][0] <= a_bus lane i; a_reg[i][j] <= a_reg[i][j-1] for j>0.
//      b_reg[0][j] <= b_bus lane j; b_reg[i][j] <= b_reg[i-1][j] for i>0.
//  - MAC, when compute_en=1 and read_en_in=0:
//      acc[i][j] <= acc[i][j] + sext(a_reg[i][j]*b_reg[i][j]); product signed 2*DW,
//      sign-extended or truncated to ACCW; sum wraps modulo 2^ACCW (no saturation).
//  - compute_en=0 and read_en_in=0: all state holds.
//  - Drain, read_en_in=1 (priority over MAC): acc[i][j] <= acc[i-1][j] for i>0, acc[0][j] <= 0.
//  - c_bus is combinational: lane j = acc[ROW_len-1][j]. While read_en_in is high,
//      cycle k after assertion presents row ROW_len-1-k. After ROW_len drain cycles all acc are 0,
//      so the next product needs no explicit clear.
//  - Feed contract: A[i][k] on lane i at cycle k+i; B[k][j] on lane j at cycle k+j; zeros otherwise.
//      Operands meet in PE(i,j) at cycle k+i+j+1. Result valid K+ROW_len+COL_len cycles after
//      first feed. Trailing zero feed flushes the pipelines.
//  - Reset mid-compute or mid-drain: all state discarded immediately; no partial results kept.
//  - read_en_in asserted mid-compute: in-flight operands keep shifting but are not accumulated.
//      Caller must finish feeding before draining.
// TESTING
//  1. Reset: rst_n=0 one cycle with nonzero operands -> c_bus=0, then all acc=0 on drain.
//  2. A1=[[1..4],[5..8],[9..12],[13..16]], B1=[[1..5],[6..10],[11..15],[16..20]], skew-fed, drain
//     -> rows 3..0: 518 576 634 692 750 / 382 424 466 508 550 / 246 272 298 324 350
//        / 110 120 130 140 150.
//  3. Back-to-back with no clear: A2 row i all (i+1), B2 = 4x4 identity + zero col 4
//     -> rows 3..0: 4 4 4 4 0 / 3 3 3 3 0 / 2 2 2 2 0 / 1 1 1 1 0.
//  4. Signed: A=-128 everywhere, B=-1 everywhere -> every C = 512; A=-3, B=5 -> every C = -60.
//  5. Overflow wrap: A=127, B=127, K=4 -> 64516 mod 65536 = -1020.
//  6. compute_en=0 for 3 cycles mid-feed, bus held -> results identical to uninterrupted run.

Source files
------------

// File: rtl/pe_array_os.sv
// ============================================================================
//  Module      : pe_array_os
//  Description : Output-stationary systolic array of signed MAC PEs with
//                bottom-edge result drain.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_array_os #(
  parameter int ROW_len = 4,
  parameter int COL_len = 5,
  parameter int DW      = 8,
  parameter int ACCW    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      compute_en,
  input  logic                      read_en_in,
  input  logic [ROW_len*DW-1:0]     a_bus,
  input  logic [COL_len*DW-1:0]     b_bus,
  output logic [COL_len*ACCW-1:0]   c_bus
);

  logic signed [DW-1:0]     r_a   [ROW_len][COL_len];
  logic signed [DW-1:0]     r_b   [ROW_len][COL_len];
  logic signed [ACCW-1:0]   r_acc [ROW_len][COL_len];
  logic signed [2*DW-1:0]   w_prod[ROW_len][COL_len];
  logic signed [ACCW-1:0]   w_ext [ROW_len][COL_len];

  for (genvar gi = 0; gi < ROW_len; gi++) begin : g_row
    for (genvar gj = 0; gj < COL_len; gj++) begin : g_col
      assign w_prod[gi][gj] = r_a[gi][gj] * r_b[gi][gj];
      // Fit the full-precision product to the accumulator width.
      if (ACCW > 2*DW) begin : g_sext
        assign w_ext[gi][gj] = {{(ACCW-2*DW){w_prod[gi][gj][2*DW-1]}}, w_prod[gi][gj]};
      end else if (ACCW == 2*DW) begin : g_same
        assign w_ext[gi][gj] = w_prod[gi][gj];
      end else begin : g_trunc
        assign w_ext[gi][gj] = w_prod[gi][gj][ACCW-1:0];
      end
    end
  end

  for (genvar gj = 0; gj < COL_len; gj++) begin : g_out
    assign c_bus[gj*ACCW +: ACCW] = r_acc[ROW_len-1][gj];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ROW_len; i++) begin
        for (int j = 0; j < COL_len; j++) begin
          r_a[i][j]   <= '0;
          r_b[i][j]   <= '0;
          r_acc[i][j] <= '0;
        end
      end
    end else begin
      if (compute_en) begin
        for (int i = 0; i < ROW_len; i++) begin
          for (int j = 0; j < COL_len; j++) begin
            r_a[i][j] <= (j == 0) ? a_bus[i*DW +: DW] : r_a[i][(j == 0) ? 0 : j-1];
            r_b[i][j] <= (i == 0) ? b_bus[j*DW +: DW] : r_b[(i == 0) ? 0 : i-1][j];
          end
        end
      end
      // Draining takes priority; operands still shift but are not accumulated.
      if (read_en_in) begin
        for (int i = 0; i < ROW_len; i++) begin
          for (int j = 0; j < COL_len; j++) begin
            r_acc[i][j] <= (i == 0) ? '0 : r_acc[(i == 0) ? 0 : i-1][j];
          end
        end
      end else if (compute_en) begin
        for (int i = 0; i < ROW_len; i++) begin
          for (int j = 0; j < COL_len; j++) begin
            r_acc[i][j] <= r_acc[i][j] + w_ext[i][j];
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pe_array_os.sv
// ============================================================================
//  Module      : tb_pe_array_os
//  Description : Scoreboard bench for pe_array_os: skewed feed, row drain.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pe_array_os;

  localparam int R    = 4;
  localparam int C    = 5;
  localparam int DW   = 8;
  localparam int AW   = 16;
  localparam int KMAX = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              compute_en;
  logic              read_en_in;
  logic [R*DW-1:0]   a_bus;
  logic [C*DW-1:0]   b_bus;
  logic [C*AW-1:0]   c_bus;

  int ma [R][KMAX];
  int mb [KMAX][C];
  int kk;

  logic [C*AW-1:0] sb_q[$];
  int n_chk = 0;
  int n_err = 0;

  pe_array_os #(.ROW_len(R), .COL_len(C), .DW(DW), .ACCW(AW)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .compute_en (compute_en),
    .read_en_in (read_en_in),
    .a_bus      (a_bus),
    .b_bus      (b_bus),
    .c_bus      (c_bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [C*AW-1:0] got, input logic [C*AW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: C = A*B wrapped to AW bits, pushed bottom row first.
  task automatic push_expected();
    logic [C*AW-1:0] row;
    logic [AW-1:0]   s;
    for (int i = R-1; i >= 0; i--) begin
      row = '0;
      for (int j = 0; j < C; j++) begin
        s = '0;
        for (int k = 0; k < kk; k++) s = s + AW'(ma[i][k] * mb[k][j]);
        row[j*AW +: AW] = s;
      end
      sb_q.push_back(row);
    end
  endtask

  task automatic push_zero_rows();
    for (int i = 0; i < R; i++) sb_q.push_back('0);
  endtask

  task automatic feed(input int pause_at);
    int k;
    compute_en = 1'b1;
    for (int t = 0; t < kk + 2*(R+C); t++) begin
      for (int i = 0; i < R; i++) begin
        k = t - i;
        a_bus[i*DW +: DW] = '0;
        if (k >= 0 && k < kk) a_bus[i*DW +: DW] = DW'(ma[i][k]);
      end
      for (int j = 0; j < C; j++) begin
        k = t - j;
        b_bus[j*DW +: DW] = '0;
        if (k >= 0 && k < kk) b_bus[j*DW +: DW] = DW'(mb[k][j]);
      end
      if (t == pause_at) begin
        compute_en = 1'b0;
        repeat (3) tick();
        compute_en = 1'b1;
      end
      tick();
    end
    compute_en = 1'b0;
    a_bus      = '0;
    b_bus      = '0;
  endtask

  task automatic drain(input string tag);
    read_en_in = 1'b1;
    for (int k = 0; k < R; k++) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL %s_row%0d got %h exp <scoreboard empty>", tag, R-1-k, c_bus);
      end else begin
        chk($sformatf("%s_row%0d", tag, R-1-k), c_bus, sb_q.pop_front());
      end
      tick();
    end
    read_en_in = 1'b0;
  endtask

  task automatic set_uniform(input int av, input int bv);
    for (int i = 0; i < R; i++) for (int k = 0; k < KMAX; k++) ma[i][k] = av;
    for (int k = 0; k < KMAX; k++) for (int j = 0; j < C; j++) mb[k][j] = bv;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    compute_en = 1'b0;
    read_en_in = 1'b0;
    a_bus      = '0;
    b_bus      = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    chk("reset_c", c_bus, '0);

    // Build up nonzero state, then reset with live operands on the bus.
    a_bus      = {R{8'h11}};
    b_bus      = {C{8'h22}};
    compute_en = 1'b1;
    repeat (8) tick();
    rst_n = 1'b0;
    tick();
    rst_n      = 1'b1;
    compute_en = 1'b0;
    a_bus      = '0;
    b_bus      = '0;
    chk("midreset_c", c_bus, '0);
    push_zero_rows();
    drain("reset_drain");

    // A1 x B1
    kk = 4;
    for (int i = 0; i < R; i++) for (int k = 0; k < kk; k++) ma[i][k] = i*4 + k + 1;
    for (int k = 0; k < kk; k++) for (int j = 0; j < C; j++) mb[k][j] = k*5 + j + 1;
    push_expected();
    feed(-1);
    drain("t2");

    // Back-to-back: identity-like B, no explicit clear
    for (int i = 0; i < R; i++) for (int k = 0; k < kk; k++) ma[i][k] = i + 1;
    for (int k = 0; k < kk; k++) for (int j = 0; j < C; j++) mb[k][j] = (k == j) ? 1 : 0;
    push_expected();
    feed(-1);
    drain("t3");

    set_uniform(-128, -1);
    push_expected();
    feed(-1);
    drain("t4_neg");

    set_uniform(-3, 5);
    push_expected();
    feed(-1);
    drain("t4_mix");

    set_uniform(127, 127);
    push_expected();
    feed(-1);
    drain("t5_wrap");

    // Stall mid-feed must not change the result
    for (int i = 0; i < R; i++) for (int k = 0; k < kk; k++) ma[i][k] = i*4 + k + 1;
    for (int k = 0; k < kk; k++) for (int j = 0; j < C; j++) mb[k][j] = k*5 + j + 1;
    push_expected();
    feed(3);
    drain("t6_stall");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

`default_nettype wire
